// File: rtl/player_motion_ctrl.sv
// Player sprite motion: horizontal walking plus a GROUND/RISE/FALL/BUMP jump FSM stepped by tick.
// Define DOUBLE_JUMP_EN to allow one extra jump while airborne (credit reloads on landing).
module player_motion_ctrl #(
  parameter int X_INIT    = 250,
  parameter int Y_INIT    = 250,
  parameter int X_MAX     = 504,
  parameter int Y_MAX     = 360,
  parameter int JUMP_V    = 8,
  parameter int GRAVITY   = 1,
  parameter int VFALL_MAX = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       col_floor,
  input  logic       col_ceil,
  input  logic       col_left,
  input  logic       col_right,
  output logic [9:0] x_pos,
  output logic [8:0] y_pos,
  output logic [2:0] blue_state,
  output logic [1:0] mstate
);

  typedef enum logic [1:0] {
    S_GROUND = 2'b00,
    S_RISE   = 2'b01,
    S_FALL   = 2'b10,
    S_BUMP   = 2'b11
  } mstate_e;

  localparam logic signed [7:0]  VY_JUMP = 8'(-JUMP_V);
  localparam logic signed [7:0]  VY_GRAV = 8'(GRAVITY);
  localparam logic signed [7:0]  VY_TERM = 8'(VFALL_MAX);
  localparam logic        [9:0]  X_LIM   = 10'(X_MAX);
  localparam logic        [8:0]  Y_LIM   = 9'(Y_MAX);
  localparam logic signed [10:0] Y_LIM_S = 11'(Y_MAX);

  mstate_e            state_q, state_d;
  logic [9:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic signed [7:0]  vy_q, vy_d;
  logic               facing_q, facing_d;
  logic               moving_q, moving_d;
  logic               airborne_q, airborne_d;
  logic               jump_hist_q;
  logic               jump_pend_q, jump_pend_d;
  logic               jump_edge;
  logic               step;
  logic               air_jump;

  logic signed [10:0] y_sum;
  logic               hit_top;
  logic               hit_floor;
  logic [8:0]         y_sat;
  logic signed [7:0]  vy_grav;
  logic signed [7:0]  vy_fall;

`ifdef DOUBLE_JUMP_EN
  logic credit_q, credit_d;
  assign air_jump = jump_pend_q && credit_q && !col_ceil;
`else
  assign air_jump = 1'b0;
`endif

  assign step      = tick && run;
  assign jump_edge = key_jump && !jump_hist_q;

  assign y_sum     = $signed({2'b00, y_q}) + $signed({{3{vy_q[7]}}, vy_q});
  assign hit_top   = (y_sum <= 11'sd0);
  assign hit_floor = (y_sum >= Y_LIM_S);
  assign y_sat     = hit_top ? '0 : (hit_floor ? Y_LIM : y_sum[8:0]);
  assign vy_grav   = vy_q + VY_GRAV;
  assign vy_fall   = (vy_grav > VY_TERM) ? VY_TERM : vy_grav;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FALL;
      x_q         <= 10'(X_INIT);
      y_q         <= 9'(Y_INIT);
      vy_q        <= '0;
      facing_q    <= 1'b0;
      moving_q    <= 1'b0;
      airborne_q  <= 1'b1;
      jump_hist_q <= 1'b0;
      jump_pend_q <= 1'b0;
`ifdef DOUBLE_JUMP_EN
      credit_q    <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      facing_q    <= facing_d;
      moving_q    <= moving_d;
      airborne_q  <= airborne_d;
      jump_hist_q <= key_jump;
      jump_pend_q <= jump_pend_d;
`ifdef DOUBLE_JUMP_EN
      credit_q    <= credit_d;
`endif
    end
  end

  // An edge arriving on the consuming tick is kept for the following tick.
  always_comb begin
    jump_pend_d = jump_pend_q || jump_edge;
    if (!run) begin
      jump_pend_d = 1'b0;
    end else if (tick) begin
      jump_pend_d = jump_edge;
    end
  end

  always_comb begin
    x_d      = x_q;
    facing_d = facing_q;
    moving_d = moving_q;
    if (step) begin
      if (key_left && !key_right) begin
        facing_d = 1'b0;
        moving_d = 1'b1;
        if (!col_left && (x_q != '0)) x_d = x_q - 10'd1;
      end else if (key_right && !key_left) begin
        facing_d = 1'b1;
        moving_d = 1'b1;
        if (!col_right && (x_q < X_LIM)) x_d = x_q + 10'd1;
      end else begin
        moving_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vy_d    = vy_q;
`ifdef DOUBLE_JUMP_EN
    credit_d = credit_q;
`endif
    if (step) begin
      unique case (state_q)
        S_GROUND: begin
          vy_d = '0;
          if (jump_pend_q && !col_ceil) begin
            state_d = S_RISE;
            vy_d    = VY_JUMP;
          end else if (!col_floor) begin
            state_d = S_FALL;
          end
        end
        S_RISE: begin
          if (col_ceil) begin
            state_d = S_BUMP;
            vy_d    = '0;
          end else if (air_jump) begin
            vy_d = VY_JUMP;
`ifdef DOUBLE_JUMP_EN
            credit_d = 1'b0;
`endif
          end else if (hit_top) begin
            // Reaching the top edge behaves exactly like hitting a ceiling block.
            state_d = S_BUMP;
            y_d     = '0;
            vy_d    = '0;
          end else begin
            y_d  = y_sat;
            vy_d = vy_grav;
            if (!vy_grav[7]) state_d = S_FALL;
          end
        end
        S_BUMP: begin
          state_d = S_FALL;
          vy_d    = '0;
        end
        S_FALL: begin
          if (air_jump) begin
            state_d = S_RISE;
            vy_d    = VY_JUMP;
`ifdef DOUBLE_JUMP_EN
            credit_d = 1'b0;
`endif
          end else if (col_floor) begin
            state_d = S_GROUND;
            vy_d    = '0;
          end else if (hit_floor) begin
            state_d = S_GROUND;
            y_d     = Y_LIM;
            vy_d    = '0;
          end else begin
            y_d  = y_sat;
            vy_d = vy_fall;
          end
        end
        default: state_d = S_FALL;
      endcase
    end
`ifdef DOUBLE_JUMP_EN
    if (state_d == S_GROUND) credit_d = 1'b1;
`endif
    airborne_d = (state_d != S_GROUND);
  end

  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign blue_state = {moving_q, airborne_q, facing_q};
  assign mstate     = state_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl; follows DOUBLE_JUMP_EN the same way as the design.
module tb_player_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       run = 1'b1;
  logic       key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
  logic       col_floor = 1'b0, col_ceil = 1'b0, col_left = 1'b0, col_right = 1'b0;
  logic [9:0] x_pos;
  logic [8:0] y_pos;
  logic [2:0] blue_state;
  logic [1:0] mstate;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  localparam int GROUND = 0, RISE = 1, FALL = 2, BUMP = 3;

  player_motion_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .run(run),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .col_floor(col_floor), .col_ceil(col_ceil), .col_left(col_left), .col_right(col_right),
    .x_pos(x_pos), .y_pos(y_pos), .blue_state(blue_state), .mstate(mstate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read there too.
  task automatic step();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic jump_pulse();
    @(negedge clk); key_jump = 1'b1;
    @(negedge clk); key_jump = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int y_exp, vy_exp;

    repeat (3) @(negedge clk);
    chk("rst_x", x_pos, 250);
    chk("rst_y", y_pos, 250);
    chk("rst_state", mstate, FALL);
    chk("rst_blue", blue_state, 3'b010);
    rst = 1'b0;

    // Land on a floor block
    col_floor = 1'b1;
    step();
    chk("land_state", mstate, GROUND);
    chk("land_x", x_pos, 250);
    chk("land_y", y_pos, 250);
    chk("land_blue", blue_state, 3'b000);

    // Ground jump: launch tick holds y, then 8 rising ticks to apex
    jump_pulse();
    step();
    chk("launch_state", mstate, RISE);
    chk("launch_y", y_pos, 250);
    chk("launch_blue", blue_state, 3'b010);
    col_floor = 1'b0;
    y_exp = 250; vy_exp = -8;
    for (int k = 1; k <= 8; k++) begin
      step();
      y_exp  += vy_exp;
      vy_exp += 1;
      chk($sformatf("rise_y_%0d", k), y_pos, y_exp);
      chk($sformatf("rise_state_%0d", k), mstate, (vy_exp >= 0) ? FALL : RISE);
    end
    chk("apex_y", y_pos, 214);

    // Second jump edge while falling
    jump_pulse();
    step();
`ifdef DOUBLE_JUMP_EN
    chk("dj_state", mstate, RISE);
    chk("dj_y", y_pos, 214);
    step();
    chk("dj_y2", y_pos, 206);
    jump_pulse();
    step();
    chk("dj3_state", mstate, RISE);
    chk("dj3_y", y_pos, 199);
`else
    chk("dj_state", mstate, FALL);
    chk("dj_y", y_pos, 214);
    step();
    chk("dj_y2", y_pos, 215);
    chk("dj_state2", mstate, FALL);
`endif

    // Reset mid-air while a tick is asserted
    @(negedge clk); rst = 1'b1; tick = 1'b1;
    @(negedge clk); rst = 1'b0; tick = 1'b0;
    chk("midrst_y", y_pos, 250);
    chk("midrst_state", mstate, FALL);
    chk("midrst_blue", blue_state, 3'b010);

    // Ceiling and floor together while rising -> BUMP, then FALL with vy=0
    col_floor = 1'b1;
    step();
    jump_pulse();
    step();
    col_floor = 1'b0;
    step();
    chk("pre_bump_y", y_pos, 242);
    col_ceil = 1'b1; col_floor = 1'b1;
    step();
    chk("bump_state", mstate, BUMP);
    chk("bump_y", y_pos, 242);
    col_ceil = 1'b0; col_floor = 1'b0;
    step();
    chk("post_bump_state", mstate, FALL);
    chk("post_bump_y", y_pos, 242);
    step();
    chk("post_bump_y2", y_pos, 242);
    step();
    chk("post_bump_y3", y_pos, 243);

    // Free fall from y=250: terminal speed then clamp at 360
    do_reset();
    repeat (7) step();
    chk("fall7_y", y_pos, 271);
    step();
    chk("fall8_y", y_pos, 277);
    repeat (13) step();
    chk("fall21_y", y_pos, 355);
    chk("fall21_state", mstate, FALL);
    step();
    chk("clamp_y", y_pos, 360);
    chk("clamp_state", mstate, GROUND);
    chk("clamp_blue", blue_state, 3'b000);

    // Horizontal motion on the ground
    col_floor = 1'b1;
    key_left = 1'b1; key_right = 1'b1;
    repeat (5) step();
    chk("both_x", x_pos, 250);
    chk("both_blue", blue_state, 3'b000);
    key_left = 1'b0;
    step();
    chk("right_x", x_pos, 251);
    chk("right_blue", blue_state, 3'b101);
    key_right = 1'b0; key_left = 1'b1;
    step();
    chk("left_x", x_pos, 250);
    chk("left_blue", blue_state, 3'b100);
    col_left = 1'b1;
    step();
    chk("colleft_x", x_pos, 250);
    chk("colleft_blue", blue_state, 3'b100);
    col_left = 1'b0;
    repeat (250) step();
    chk("xmin_x", x_pos, 0);
    step();
    chk("xmin_hold", x_pos, 0);
    key_left = 1'b0; key_right = 1'b1;
    repeat (504) step();
    chk("xmax_x", x_pos, 504);
    step();
    chk("xmax_hold", x_pos, 504);
    chk("xmax_blue", blue_state, 3'b101);

    // Frozen while run=0
    key_right = 1'b0; key_left = 1'b1; run = 1'b0;
    step();
    chk("frozen_x", x_pos, 504);
    chk("frozen_state", mstate, GROUND);
    run = 1'b1; key_left = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
